// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/response bus between the LSU and memory
interface load_store_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store stage: bus handshake, lane alignment, load extension, faults
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         func3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic [31:0]        load_data,
  output logic               stall,
  output logic               fault,
  output logic [1:0]         fault_cause,
  load_store_unit_if.master  bus
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, FAULT} state_t;

  // Counter compare value: the abort happens on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [2:0]  lat_func3;
  logic [1:0]  lat_off;

  logic        access;
  logic        legal_f3;
  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] wdata_lane;
  logic [3:0]  wstrb_lane;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_ext;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (tmo_cnt == TMO_LAST);
  assign stall       = ((state == IDLE) && access) || (state == REQ) || (state == RESP);

  // Decode the incoming instruction: legality, alignment and store lane placement.
  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    wdata_lane = store_data;
    wstrb_lane = 4'b1111;
    if (mem_write) legal_f3 = func3 inside {3'b000, 3'b001, 3'b010};
    else           legal_f3 = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (func3[1:0] == 2'b01) misaligned = addr[0];
    if (func3[1:0] == 2'b10) misaligned = (addr[1:0] != 2'b00);
    case (func3[1:0])
      2'b00: begin
        wdata_lane = {4{store_data[7:0]}};
        wstrb_lane = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_lane = {2{store_data[15:0]}};
        wstrb_lane = 4'b0011 << addr[1:0];
      end
      default: begin
        wdata_lane = store_data;
        wstrb_lane = 4'b1111;
      end
    endcase
  end

  // Pick the addressed byte/half out of the read word and extend it per the latched funct3.
  always_comb begin
    rsp_byte = bus.bus_rsp_rdata[{lat_off, 3'b000} +: 8];
    rsp_half = lat_off[1] ? bus.bus_rsp_rdata[31:16] : bus.bus_rsp_rdata[15:0];
    case (lat_func3)
      3'b000:  load_ext = {{24{rsp_byte[7]}}, rsp_byte};
      3'b001:  load_ext = {{16{rsp_half[15]}}, rsp_half};
      3'b100:  load_ext = {24'd0, rsp_byte};
      3'b101:  load_ext = {16'd0, rsp_half};
      default: load_ext = bus.bus_rsp_rdata;
    endcase
  end

  // Access sequencer with registered bus request, load result and fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      tmo_cnt           <= 16'd0;
      lat_func3         <= 3'b000;
      lat_off           <= 2'b00;
      load_data         <= 32'd0;
      fault             <= 1'b0;
      fault_cause       <= 2'b00;
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= 32'd0;
      bus.bus_req_write <= 1'b0;
      bus.bus_req_wdata <= 32'd0;
      bus.bus_req_wstrb <= 4'b0000;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            lat_func3 <= func3;
            lat_off   <= addr[1:0];
            if ((mem_read && mem_write) || !legal_f3) begin
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= 2'b11;
            end else if (misaligned) begin
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              state             <= REQ;
              tmo_cnt           <= 16'd0;
              bus.bus_req_valid <= 1'b1;
              bus.bus_req_addr  <= {addr[31:2], 2'b00};
              bus.bus_req_write <= mem_write;
              bus.bus_req_wdata <= mem_write ? wdata_lane : 32'd0;
              bus.bus_req_wstrb <= mem_write ? wstrb_lane : 4'b0000;
            end
          end
        end
        REQ: begin
          if (timeout_hit) begin
            state             <= FAULT;
            fault             <= 1'b1;
            fault_cause       <= 2'b10;
            bus.bus_req_valid <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (bus.bus_req_ready) begin
              state             <= RESP;
              bus.bus_req_valid <= 1'b0;
            end
          end
        end
        RESP: begin
          if (timeout_hit) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (bus.bus_rsp_valid) begin
              state <= DONE;
              if (!bus.bus_req_write) load_data <= load_ext;
            end
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    int          rdy;
    int          rsp;
    logic [31:0] rdata;
    logic [31:0] lit_ld;
    logic [31:0] lit_addr;
    logic [31:0] lit_wd;
    logic [3:0]  lit_ws;
    logic [1:0]  lit_cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, fault;
  logic [1:0]  fault_cause;

  logic        b_mem_read, b_mem_write;
  logic [2:0]  b_func3;
  logic [31:0] b_addr, b_store_data, b_load_data;
  logic        b_stall, b_fault;
  logic [1:0]  b_fault_cause;

  load_store_unit_if bus();
  load_store_unit_if b_bus();

  int n_checks = 0;
  int n_fail   = 0;

  logic        cur_rd, cur_wr;
  logic [2:0]  cur_f3;
  logic [31:0] cur_a, cur_sd;
  logic [1:0]  exp_cause;
  logic [31:0] model_ld;
  int          valid_cycles;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_write;

  int          cfg_rdy, cfg_rsp;
  logic        cfg_rsp_en, force_rsp;
  logic [31:0] cfg_rdata;
  int          ph, w;

  vec_t vecs[18];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
    .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
    .fault(fault), .fault_cause(fault_cause), .bus(bus)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_tmo (
    .clk(clk), .rst(rst), .mem_read(b_mem_read), .mem_write(b_mem_write), .func3(b_func3),
    .addr(b_addr), .store_data(b_store_data), .load_data(b_load_data), .stall(b_stall),
    .fault(b_fault), .fault_cause(b_fault_cause), .bus(b_bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_cause(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    if (rd && wr) return 2'b11;
    if (f3[1:0] == 2'b11) return 2'b11;
    if (wr && f3[2]) return 2'b11;
    if (f3 == 3'b110) return 2'b11;
    if ((a % nb) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_wstrb(logic wr, logic [2:0] f3, logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    if (!wr) return 4'b0000;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] sd);
    logic [31:0] wd;
    int nb;
    nb = 1 << f3[1:0];
    wd = 32'd0;
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = sd[8*(k % nb) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    logic [31:0] v, mask;
    int nb;
    nb = 1 << f3[1:0];
    if (nb >= 4) return rdata;
    v    = rdata >> (8 * (a % 4));
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v    = v & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Memory model for the main instance: configurable ready and response delays.
  always @(negedge clk) begin
    if (rst) begin
      ph = 0; w = 0;
      bus.bus_req_ready = 1'b0;
      bus.bus_rsp_valid = 1'b0;
      bus.bus_rsp_rdata = 32'd0;
    end else begin
      case (ph)
        0: begin
          bus.bus_req_ready = 1'b0;
          bus.bus_rsp_valid = force_rsp;
          bus.bus_rsp_rdata = cfg_rdata;
          if (bus.bus_req_valid) begin
            if (w >= cfg_rdy) begin
              bus.bus_req_ready = 1'b1;
              ph = 1; w = 0;
            end else w++;
          end
        end
        1: begin
          bus.bus_req_ready = 1'b0;
          if (cfg_rsp_en && w >= cfg_rsp) begin
            bus.bus_rsp_valid = 1'b1;
            bus.bus_rsp_rdata = cfg_rdata;
            if (!cur_wr) model_ld = m_load(cur_f3, cur_a, cfg_rdata);
            ph = 2;
          end else w++;
        end
        default: begin
          bus.bus_rsp_valid = 1'b0;
          ph = 0; w = 0;
        end
      endcase
    end
  end

  // Per-cycle compare of the main instance against the model.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("load_data_hold", load_data, model_ld);
      if (bus.bus_req_valid) begin
        valid_cycles++;
        chk("req_for_faulting_access", {30'd0, exp_cause}, 32'd0);
        chk("req_addr", bus.bus_req_addr, cur_a & 32'hFFFF_FFFC);
        chk("req_write", {31'd0, bus.bus_req_write}, {31'd0, cur_wr});
        chk("req_wstrb", {28'd0, bus.bus_req_wstrb}, {28'd0, m_wstrb(cur_wr, cur_f3, cur_a)});
        if (cur_wr) chk("req_wdata", bus.bus_req_wdata, m_wdata(cur_f3, cur_sd));
        last_addr  = bus.bus_req_addr;
        last_wdata = bus.bus_req_wdata;
        last_wstrb = bus.bus_req_wstrb;
        last_write = bus.bus_req_write;
      end
      if (fault) chk("fault_cause_model", {30'd0, fault_cause}, {30'd0, exp_cause});
    end
  end

  task automatic run_op(input vec_t v);
    int n;
    @(posedge clk); #1;
    cur_rd = v.rd; cur_wr = v.wr; cur_f3 = v.f3; cur_a = v.a; cur_sd = v.sd;
    exp_cause = m_cause(v.rd, v.wr, v.f3, v.a);
    chk("model_cause_pin", {30'd0, exp_cause}, {30'd0, v.lit_cause});
    cfg_rdy = v.rdy; cfg_rsp = v.rsp; cfg_rdata = v.rdata; cfg_rsp_en = 1'b1;
    valid_cycles = 0;
    mem_read = v.rd; mem_write = v.wr; func3 = v.f3; addr = v.a; store_data = v.sd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall || n >= 400) break;
      n++;
    end
    chk("stall_cycles", 32'(n), (exp_cause != 2'b00) ? 32'd1 : 32'(3 + v.rdy + v.rsp));
    chk("fault_pulse", {31'd0, fault}, {31'd0, (v.lit_cause != 2'b00)});
    if (v.lit_cause != 2'b00) chk("fault_cause", {30'd0, fault_cause}, {30'd0, v.lit_cause});
    chk("load_data", load_data, v.lit_ld);
    chk("valid_cycles", 32'(valid_cycles), (v.lit_cause != 2'b00) ? 32'd0 : 32'(v.rdy + 1));
    if (v.lit_cause == 2'b00) begin
      chk("bus_addr", last_addr, v.lit_addr);
      chk("bus_wstrb", {28'd0, last_wstrb}, {28'd0, v.lit_ws});
      chk("bus_write", {31'd0, last_write}, {31'd0, v.wr});
      if (v.wr) chk("bus_wdata", last_wdata, v.lit_wd);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("fault_one_cycle", {31'd0, fault}, 32'd0);
    chk("stall_idle", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //        rd    wr    f3      a          sd            rdy rsp rdata         lit_ld        lit_addr   lit_wd        ws       cause
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h0,        4'b0000, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'hA5,       2, 0, 32'h0,        32'hDEADBEEF, 32'h200, 32'hA5A5A5A5, 4'b1000, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h2,   32'h0,        0, 0, 32'h00800000, 32'hFFFFFF80, 32'h0,   32'h0,        4'b0000, 2'b00};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h2,   32'h0,        0, 0, 32'h00800000, 32'h00000080, 32'h0,   32'h0,        4'b0000, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h2,   32'h0,        0, 0, 32'h80010000, 32'h00008001, 32'h0,   32'h0,        4'b0000, 2'b00};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h55555555, 32'h00008001, 32'h0,   32'h0,        4'b0000, 2'b01};
    vecs[6]  = '{1'b1, 1'b1, 3'b010, 32'h0,   32'h0,        0, 0, 32'h55555555, 32'h00008001, 32'h0,   32'h0,        4'b0000, 2'b11};
    vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'h6,   32'h0,        1, 2, 32'h80011234, 32'hFFFF8001, 32'h4,   32'h0,        4'b0000, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h2,   32'h1234BEEF, 0, 1, 32'h0,        32'hFFFF8001, 32'h0,   32'hBEEFBEEF, 4'b1100, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'hCAFEF00D, 1, 0, 32'h0,        32'hFFFF8001, 32'h10,  32'hCAFEF00D, 4'b1111, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0,   32'h0,        0, 0, 32'h0,        32'hFFFF8001, 32'h0,   32'h0,        4'b0000, 2'b11};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h0,   32'h0,        0, 0, 32'h0,        32'hFFFF8001, 32'h0,   32'h0,        4'b0000, 2'b11};
    vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h1,   32'h0,        0, 0, 32'h0,        32'hFFFF8001, 32'h0,   32'h0,        4'b0000, 2'b01};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h8,   32'h0,        0, 3, 32'h0BADF00D, 32'h0BADF00D, 32'h8,   32'h0,        4'b0000, 2'b00};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h1,   32'h0,        0, 0, 32'h0000FF00, 32'hFFFFFFFF, 32'h0,   32'h0,        4'b0000, 2'b00};
    vecs[15] = '{1'b1, 1'b0, 3'b101, 32'h0,   32'h0,        0, 0, 32'hFFFF7FFE, 32'h00007FFE, 32'h0,   32'h0,        4'b0000, 2'b00};
    vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h4,   32'h12345678, 0, 0, 32'h0,        32'h00007FFE, 32'h4,   32'h78787878, 4'b0001, 2'b00};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h2,   32'h0,        0, 0, 32'h0,        32'h00007FFE, 32'h0,   32'h0,        4'b0000, 2'b01};

    mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000; addr = 32'd0; store_data = 32'd0;
    b_mem_read = 1'b0; b_mem_write = 1'b0; b_func3 = 3'b000; b_addr = 32'd0; b_store_data = 32'd0;
    b_bus.bus_req_ready = 1'b1; b_bus.bus_rsp_valid = 1'b0; b_bus.bus_rsp_rdata = 32'd0;
    cur_rd = 1'b0; cur_wr = 1'b0; cur_f3 = 3'b000; cur_a = 32'd0; cur_sd = 32'd0;
    exp_cause = 2'b00; model_ld = 32'd0; valid_cycles = 0;
    last_addr = 32'd0; last_wdata = 32'd0; last_wstrb = 4'b0000; last_write = 1'b0;
    cfg_rdy = 0; cfg_rsp = 0; cfg_rsp_en = 1'b1; force_rsp = 1'b0; cfg_rdata = 32'd0;

    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fault", {30'd0, fault_cause, fault}, 32'd0);
    chk("rst_req_valid", {31'd0, bus.bus_req_valid}, 32'd0);
    chk("rst_req_fields", bus.bus_req_addr | bus.bus_req_wdata | {27'd0, bus.bus_req_write, bus.bus_req_wstrb}, 32'd0);
    chk("rst_tmo_unit", {b_load_data[30:0], b_bus.bus_req_valid}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Asynchronous reset while a load waits in RESP.
    @(posedge clk); #1;
    cur_rd = 1'b1; cur_wr = 1'b0; cur_f3 = 3'b010; cur_a = 32'h300; cur_sd = 32'd0;
    exp_cause = 2'b00; cfg_rdy = 0; cfg_rsp_en = 1'b0; cfg_rdata = 32'h99999999; valid_cycles = 0;
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h300;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid_cycles > 0 && !bus.bus_req_valid) && n < 50);
    chk("reached_resp", {31'd0, (n < 50)}, 32'd1);
    chk("resp_stall", {31'd0, stall}, 32'd1);
    #1;
    rst = 1'b1; mem_read = 1'b0; model_ld = 32'd0;
    #1;
    chk("arst_load_data", load_data, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_req_valid", {31'd0, bus.bus_req_valid}, 32'd0);
    chk("arst_req_fields", bus.bus_req_addr | bus.bus_req_wdata | {27'd0, bus.bus_req_write, bus.bus_req_wstrb}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    force_rsp = 1'b1; cfg_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    chk("late_rsp_load_data", load_data, 32'd0);
    chk("late_rsp_stall", {31'd0, stall}, 32'd0);
    chk("late_rsp_req_valid", {31'd0, bus.bus_req_valid}, 32'd0);
    force_rsp = 1'b0;
    @(negedge clk);
    run_op('{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h11223344, 32'h11223344, 32'h100, 32'h0, 4'b0000, 2'b00});

    // Timeout on the TIMEOUT_CYCLES=4 instance: request accepted, response never comes.
    @(posedge clk); #1;
    b_mem_read = 1'b1; b_func3 = 3'b010; b_addr = 32'h40;
    n = 0;
    forever begin
      @(negedge clk);
      if (!b_stall || n >= 50) break;
      n++;
    end
    chk("tmo_stall_cycles", 32'(n), 32'd5);
    chk("tmo_fault", {31'd0, b_fault}, 32'd1);
    chk("tmo_cause", {30'd0, b_fault_cause}, 32'd2);
    chk("tmo_req_valid", {31'd0, b_bus.bus_req_valid}, 32'd0);
    chk("tmo_load_data", b_load_data, 32'd0);
    @(posedge clk); #1;
    b_mem_read = 1'b0;
    @(negedge clk);
    chk("tmo_fault_clear", {31'd0, b_fault}, 32'd0);
    chk("tmo_bus_idle", {30'd0, b_bus.bus_req_valid, b_stall}, 32'd0);
    @(posedge clk); #1;
    b_mem_read = 1'b1; b_addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_next_req_valid", {31'd0, b_bus.bus_req_valid}, 32'd1);
    @(negedge clk);
    b_bus.bus_rsp_valid = 1'b1; b_bus.bus_rsp_rdata = 32'h12345678;
    @(negedge clk);
    chk("tmo_next_done_stall", {31'd0, b_stall}, 32'd0);
    chk("tmo_next_fault", {31'd0, b_fault}, 32'd0);
    chk("tmo_next_load_data", b_load_data, 32'h12345678);
    b_bus.bus_rsp_valid = 1'b0;
    @(posedge clk); #1;
    b_mem_read = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the main decoder in the RV32I core; consumes mem_read / mem_write / funct3 plus the ALU-computed address and rs2 data.
- Runs a valid/ready request plus response handshake to data memory, aligns store bytes, and sign/zero-extends load data.
- Stalls the core while an access is in flight and reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+RESP before abort; range 1..65535.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous active-high reset.
mem_read  input  1  load requested by current instruction.
mem_write  input  1  store requested by current instruction.
func3  input  3  instruction funct3 (size/sign).
addr  input  32  byte address from ALU.
store_data  input  32  rs2 value.
load_data  output  32  extended load result; valid in DONE.
stall  output  1  core must hold PC/regfile when high.
fault  output  1  one-cycle fault pulse.
fault_cause  output  2  01 misaligned, 10 timeout, 11 illegal (bad func3 or read+write); valid with fault.
bus_req_valid  output  1  request valid.
bus_req_ready  input  1  memory accepts request.
bus_req_addr  output  32  word address (addr with [1:0]=00).
bus_req_write  output  1  1 = store.
bus_req_wdata  output  32  lane-aligned store data.
bus_req_wstrb  output  4  byte enables; 0000 for loads.
bus_rsp_valid  input  1  response/ack valid.
bus_rsp_rdata  input  32  read word.

Behaviour:
- States: IDLE, REQ, RESP, DONE, FAULT.
- Reset: state IDLE; timeout counter 0; load_data, fault, fault_cause, bus_req_* all 0. Async reset mid-transaction abandons it; bus_req_valid drops immediately.
- IDLE, no access (mem_read=mem_write=0): stall=0; stay.
- IDLE, access: stall=1; latch addr, func3, store_data and direction.
  - Both mem_read and mem_write high -> FAULT, cause 11.
  - Legal func3: load 000,001,010,100,101; store 000,001,010. Otherwise -> FAULT, cause 11.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=00) -> FAULT, cause 01.
  - Else -> REQ.
- No bus activity occurs for a faulting access.
- REQ: bus_req_valid=1; addr/write/wdata/wstrb stable from latched values.
  - bus_req_ready=1 -> RESP.
  - Otherwise hold.
- RESP: bus_req_valid=0.
  - bus_rsp_valid=1 -> DONE; a load registers extracted data into load_data, a store ignores rdata.
  - bus_rsp_valid is sampled only in RESP; responses in other states are ignored.
- DONE: stall=0 for exactly one cycle; core advances on this edge. Next state IDLE. load_data holds until the next load's DONE.
- FAULT: stall=0, fault=1 for exactly one cycle with fault_cause; next IDLE. load_data unchanged.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When counter reaches TIMEOUT_CYCLES -> FAULT, cause 10; bus_req_valid drops that edge.
  - Timeout takes priority over ready/rsp_valid arriving in the same cycle.
- Stall: combinational; 1 in IDLE (with access pending), REQ and RESP; 0 in DONE, FAULT and idle IDLE.
- Zero-wait latency: IDLE -> REQ -> RESP -> DONE, i.e. 3 stall cycles, result on the 4th.
- Store lanes (o = addr[1:0]):
  - SB: byte replicated to all 4 lanes; wstrb = 0001<<o.
  - SH: halfword replicated; wstrb = 0011<<o.
  - SW: wdata = store_data; wstrb = 1111.
- Load extraction from rdata using o:
  - LB / LBU: byte o, sign- / zero-extended to 32.
  - LH / LHU: half o[1], sign- / zero-extended.
  - LW: full word.

Test Plan:
- LW addr 0x100, zero-wait memory returning 0xDEADBEEF -> stall 1 for 3 cycles; DONE load_data=0xDEADBEEF; bus_req_addr=0x100, wstrb=0000.
- SB addr 0x203, store_data 0x000000A5, ready delayed 2 cycles -> valid held 3 cycles; wdata=0xA5A5A5A5, wstrb=1000, write=1; DONE after ack.
- LB addr 0x2 on rdata 0x00800000 -> load_data=0xFFFFFF80; repeat with LBU -> 0x00000080; LHU addr 0x2 on 0x80010000 -> 0x00008001.
- LW addr 0x102 -> no bus_req_valid, FAULT pulse with cause 01, stall low that cycle; mem_read+mem_write together -> cause 11.
- TIMEOUT_CYCLES=4, memory never responds -> fault cause 10 four cycles after entering REQ; bus idle afterward; next LW completes normally.
- rst asserted during RESP -> all outputs 0 immediately; a late bus_rsp_valid after release is ignored, state IDLE.
